// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: arbiter state encoding and memory write-enable constants
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_IF, ARB_LS} arb_state_t;
  localparam logic [3:0] MEM_WE_READ = 4'b0000;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store,
// LS-priority with a bounded LS streak, one transaction in flight at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_LS_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_kill,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  input  logic [3:0]  ls_we,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);
  localparam int SW = $clog2(MAX_LS_STREAK + 1);
  arb_state_t r_state;
  logic [SW-1:0] r_streak;
  logic r_kill;
  logic w_idle, w_ls_win, w_if_win, w_done;
  // No grants while reset is held, even though the state already reads idle
  assign w_idle   = reset && r_state == ARB_IDLE;
  assign w_ls_win = w_idle && ls_req && (!if_req || r_streak < SW'(MAX_LS_STREAK));
  assign w_if_win = w_idle && if_req && !w_ls_win;
  assign w_done   = r_state != ARB_IDLE && mem_ready;
  assign ls_gnt   = w_ls_win;
  assign if_gnt   = w_if_win;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state   <= ARB_IDLE;
      r_streak  <= '0;
      r_kill    <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= MEM_WE_READ;
      mem_wdata <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if (w_ls_win) begin
        r_state   <= ARB_LS;
        mem_req   <= 1'b1;
        mem_addr  <= ls_addr;
        mem_we    <= ls_we;
        mem_wdata <= ls_wdata;
        r_streak  <= if_req ? r_streak + SW'(1) : '0;
      end else if (w_if_win) begin
        r_state   <= ARB_IF;
        mem_req   <= 1'b1;
        mem_addr  <= if_addr;
        mem_we    <= MEM_WE_READ;
        mem_wdata <= '0;
        r_streak  <= '0;
        r_kill    <= if_kill;
      end else if (w_done) begin
        r_state <= ARB_IDLE;
        mem_req <= 1'b0;
        r_kill  <= 1'b0;
        if (r_state == ARB_LS) begin
          ls_rvalid <= 1'b1;
          ls_rdata  <= mem_we == MEM_WE_READ ? mem_rdata : '0;
        end else if (!(r_kill || if_kill)) begin
          if_rvalid <= 1'b1;
          if_rdata  <= mem_rdata;
        end
      end else if (r_state == ARB_IF && if_kill) begin
        r_kill <= 1'b1;
      end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench; stimulus pushes expected grants, memory
// transactions and responses, independent monitors pop and compare them.
module tb_mem_port_arbiter;
  logic clk = 1'b0, reset = 1'b0;
  logic if_req, if_kill, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic ls_req, ls_gnt, ls_rvalid;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0] ls_we, mem_we;
  logic mem_req, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  typedef struct {logic [31:0] addr; logic [3:0] we; logic [31:0] wdata;} mem_t;
  typedef struct {bit ls; logic [31:0] data;} rsp_t;
  mem_t q_mem[$];
  rsp_t q_rsp[$];
  bit q_gnt[$];
  logic [31:0] if_todo[$];
  mem_t ls_todo[$];
  int checks = 0, errors = 0, waits = 0, cyc = 0, gnt_cyc = 0;
  bit if_g = 0, ls_g = 0, idle_noise = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_LS_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_we(ls_we), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return a == 32'h100 ? 32'h13 : a == 32'h3004 ? 32'hA5A5A5A5 : a ^ 32'hC0DE0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic src_if(input logic [31:0] a);
    if_todo.push_back(a);
  endtask
  task automatic src_ls(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    ls_todo.push_back('{a, we, wd});
  endtask
  task automatic exp_if(input logic [31:0] a, input bit rsp, input logic [31:0] rd);
    q_gnt.push_back(1'b0);
    q_mem.push_back('{a, 4'b0000, 32'h0});
    if (rsp) q_rsp.push_back('{1'b0, rd});
  endtask
  task automatic exp_ls(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                        input bit rsp, input logic [31:0] rd);
    q_gnt.push_back(1'b1);
    q_mem.push_back('{a, we, wd});
    if (rsp) q_rsp.push_back('{1'b1, rd});
  endtask

  task automatic drain();
    int n = 0;
    while ((q_gnt.size() || q_rsp.size() || if_todo.size() || ls_todo.size() ||
            if_req || ls_req || mem_req) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d expected=<200", n);
    end
    repeat (3) @(negedge clk);
  endtask

  // Memory model: mem_ready after `waits` stall cycles, optional noise while idle
  initial begin
    int cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'hBAD0BAD0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_req && cnt == waits) begin
        mem_ready = 1'b1;
        mem_rdata = mem_val(mem_addr);
        cnt = 0;
      end else begin
        mem_ready = !mem_req && idle_noise;
        mem_rdata = 32'hBAD0BAD0;
        cnt = mem_req ? cnt + 1 : 0;
      end
    end
  end

  initial begin
    if_req = 1'b0;
    if_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (if_g) if_req = 1'b0;
      if (!if_req && if_todo.size() > 0) begin
        if_addr = if_todo.pop_front();
        if_req = 1'b1;
      end
    end
  end

  initial begin
    mem_t t;
    ls_req = 1'b0;
    ls_addr = '0;
    ls_we = '0;
    ls_wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (ls_g) ls_req = 1'b0;
      if (!ls_req && ls_todo.size() > 0) begin
        t = ls_todo.pop_front();
        ls_addr = t.addr;
        ls_we = t.we;
        ls_wdata = t.wdata;
        ls_req = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if_g <= if_gnt;
    ls_g <= ls_gnt;
  end

  initial begin
    bit prev = 0;
    mem_t cur;
    rsp_t r;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        if (if_rvalid || ls_rvalid) begin
          chk("rvalid_excl", 32'(if_rvalid && ls_rvalid), 32'h0);
          if (q_rsp.size() == 0) chk("unexpected_rvalid", {30'h0, if_rvalid, ls_rvalid}, 32'h0);
          else begin
            r = q_rsp.pop_front();
            chk("rsp_src", 32'(ls_rvalid), 32'(r.ls));
            chk("rsp_data", r.ls ? ls_rdata : if_rdata, r.data);
            chk("latency", 32'(cyc - gnt_cyc), 32'(waits + 2));
          end
        end
        if (if_gnt || ls_gnt) begin
          if (q_gnt.size() == 0) chk("unexpected_gnt", {30'h0, if_gnt, ls_gnt}, 32'h0);
          else chk("gnt_order", {30'h0, if_gnt, ls_gnt}, q_gnt.pop_front() ? 32'h1 : 32'h2);
          gnt_cyc = cyc;
        end
        if (mem_req && !prev) begin
          if (q_mem.size() == 0) chk("unexpected_mem_req", 32'(mem_req), 32'h0);
          else begin
            cur = q_mem.pop_front();
            chk("mem_addr", mem_addr, cur.addr);
            chk("mem_we", 32'(mem_we), 32'(cur.we));
            chk("mem_wdata", mem_wdata, cur.wdata);
          end
        end else if (mem_req) begin
          chk("mem_stable", {mem_addr ^ cur.addr} | 32'(mem_we ^ cur.we) | (mem_wdata ^ cur.wdata), 32'h0);
        end
        prev = mem_req;
      end else prev = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    if_kill = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mem_req", 32'(mem_req), 32'h0);
      chk("rst_rvalid", {30'h0, if_rvalid, ls_rvalid}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
    end
    @(posedge clk);
    #1 reset = 1'b1;

    waits = 2;
    src_if(32'h100);
    exp_if(32'h100, 1, 32'h13);
    drain();

    waits = 0;
    src_if(32'h400);
    src_ls(32'h2000, 4'hF, 32'hDEADBEEF);
    exp_ls(32'h2000, 4'hF, 32'hDEADBEEF, 1, 32'h0);
    exp_if(32'h400, 1, 32'hC0DE0400);
    drain();

    src_if(32'h500);
    src_if(32'h504);
    for (int i = 0; i < 8; i++) src_ls(32'h6000 + 32'(4 * i), 4'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      exp_ls(32'h6000 + 32'(4 * i), 4'h0, 32'h0, 1, 32'hC0DE6000 + 32'(4 * i));
      if (i == 3) exp_if(32'h500, 1, 32'hC0DE0500);
    end
    exp_if(32'h504, 1, 32'hC0DE0504);
    drain();

    waits = 3;
    src_if(32'h700);
    exp_if(32'h700, 0, 32'h0);
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!if_g && n < 50);
    if (n >= 50) begin
      errors++;
      $display("FAIL kill_gnt_timeout actual=%0d expected=<50", n);
    end
    #1 if_kill = 1'b1;
    @(posedge clk);
    #1 if_kill = 1'b0;
    src_if(32'h704);
    exp_if(32'h704, 1, 32'hC0DE0704);
    drain();

    waits = 0;
    idle_noise = 1;
    src_ls(32'h3004, 4'h0, 32'h12345678);
    exp_ls(32'h3004, 4'h0, 32'h12345678, 1, 32'hA5A5A5A5);
    drain();
    idle_noise = 0;

    // Reset during the first LS write; the post-reset grant order exposes a stale streak
    waits = 5;
    for (int i = 0; i < 5; i++) src_ls(32'h8000 + 32'(4 * i), 4'hF, 32'(i + 1));
    src_if(32'h900);
    exp_ls(32'h8000, 4'hF, 32'h1, 0, 32'h0);
    for (int i = 1; i < 5; i++) exp_ls(32'h8000 + 32'(4 * i), 4'hF, 32'(i + 1), 1, 32'h0);
    exp_if(32'h900, 1, 32'hC0DE0900);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 50);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mid_ls_rvalid", 32'(ls_rvalid), 32'h0);
    waits = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    drain();

    chk("q_rsp_empty", 32'(q_rsp.size()), 32'h0);
    chk("q_mem_empty", 32'(q_mem.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
